// File: rtl/sobel_hls_mul_pipe.sv
// sobel_hls_mul_pipe: parametrised pipelined integer multiplier for the sobel_hls datapath.
// NUM_STAGE register stages with valid/ready flow control, clock enable and global stall.
// The full-width product travels through the early stages. Width adaptation
// (truncate/extend) happens only at the input of the final stage.
// Optional feature macro: SOBEL_HLS_MUL_SAT_EN. When defined, narrowing saturates
// instead of truncating, and a registered sat_flag output is added.
module sobel_hls_mul_pipe #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 8,
    parameter int din1_WIDTH = 22,
    parameter int dout_WIDTH = 29,
    parameter int SIGNED     = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
`ifdef SOBEL_HLS_MUL_SAT_EN
    output logic                  sat_flag,
`endif
    output logic                  busy
);

    localparam int FW = din0_WIDTH + din1_WIDTH;

    // Stage count outside the supported range is rejected at elaboration.
    generate
        if (NUM_STAGE < 1 || NUM_STAGE > 8) begin : g_bad_stage
            $error("sobel_hls_mul_pipe %0d: NUM_STAGE must be 1..8", ID);
        end
    endgenerate

    logic                  advance;
    logic [NUM_STAGE:1]    vld;
    logic [FW-1:0]         a_ext;
    logic [FW-1:0]         b_ext;
    logic [FW-1:0]         prod;
    logic [FW-1:0]         fin_src;
    logic [dout_WIDTH-1:0] fin_res;
    logic [dout_WIDTH-1:0] dout_r;
`ifdef SOBEL_HLS_MUL_SAT_EN
    logic                  fin_sat;
    logic                  sat_r;
`endif

    // Whole pipeline moves together; a stalled valid output freezes every stage.
    assign advance   = ce & (~out_valid | out_ready);
    assign in_ready  = advance & ~reset;
    assign out_valid = vld[NUM_STAGE];
    assign busy      = |vld;
    assign dout      = dout_r;

    // Operands extended to the full product width. The low FW bits of the
    // product are then correct for both signed and unsigned operands.
    assign a_ext = (SIGNED != 0) ? {{din1_WIDTH{din0[din0_WIDTH-1]}}, din0}
                                 : {{din1_WIDTH{1'b0}}, din0};
    assign b_ext = (SIGNED != 0) ? {{din0_WIDTH{din1[din1_WIDTH-1]}}, din1}
                                 : {{din0_WIDTH{1'b0}}, din1};
    assign prod  = a_ext * b_ext;

    // Valid shift register: bubbles are kept as holes and never collapsed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld <= '0;
        end else if (advance) begin
            vld[1] <= in_valid;
            for (int k = 2; k <= NUM_STAGE; k++) vld[k] <= vld[k-1];
        end
    end

    // Full-width data stages that precede the final stage.
    generate
        if (NUM_STAGE == 1) begin : g_one
            assign fin_src = prod;
        end else begin : g_mid
            logic [FW-1:0] pdat [1:NUM_STAGE-1];

            // Each stage shifts its product forward on advance.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    for (int k = 1; k < NUM_STAGE; k++) pdat[k] <= '0;
                end else if (advance) begin
                    pdat[1] <= prod;
                    for (int k = 2; k < NUM_STAGE; k++) pdat[k] <= pdat[k-1];
                end
            end

            assign fin_src = pdat[NUM_STAGE-1];
        end
    endgenerate

    // Result formation feeding the final stage.
    generate
        if (dout_WIDTH > FW) begin : g_wide
            assign fin_res = {{(dout_WIDTH-FW){(SIGNED != 0) ? fin_src[FW-1] : 1'b0}}, fin_src};
`ifdef SOBEL_HLS_MUL_SAT_EN
            assign fin_sat = 1'b0;
`endif
        end else if (dout_WIDTH == FW) begin : g_equal
            assign fin_res = fin_src;
`ifdef SOBEL_HLS_MUL_SAT_EN
            assign fin_sat = 1'b0;
`endif
        end else begin : g_narrow
`ifdef SOBEL_HLS_MUL_SAT_EN
            logic ovf;
            if (SIGNED != 0) begin : g_sgn
                // Fits only when all dropped bits match the new sign bit.
                assign ovf = ~((&fin_src[FW-1:dout_WIDTH-1]) | ~(|fin_src[FW-1:dout_WIDTH-1]));
                assign fin_res = ovf ? {fin_src[FW-1], {(dout_WIDTH-1){~fin_src[FW-1]}}}
                                     : fin_src[dout_WIDTH-1:0];
            end else begin : g_uns
                assign ovf = |fin_src[FW-1:dout_WIDTH];
                assign fin_res = ovf ? {dout_WIDTH{1'b1}} : fin_src[dout_WIDTH-1:0];
            end
            assign fin_sat = ovf;
`else
            assign fin_res = fin_src[dout_WIDTH-1:0];
`endif
        end
    endgenerate

    // Final stage: holds dout stable until the output handshake completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dout_r <= '0;
        end else if (advance) begin
            dout_r <= fin_res;
        end
    end

`ifdef SOBEL_HLS_MUL_SAT_EN
    // Saturation flag registered alongside dout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sat_r <= 1'b0;
        end else if (advance) begin
            sat_r <= fin_sat;
        end
    end

    assign sat_flag = sat_r;
`endif

endmodule
